// File: rtl/str_keep_gen.sv
// Feeds the stream offset converter. It turns one transfer command into a conv offset pair and a tkeep-masked, tlast-framed aligned beat stream.
// Optional raw framing check: define STR_KEEP_GEN_FRAME_CHK_EN to add o_err.
module str_keep_gen #(
  parameter int DATA_WIDTH = 512,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  localparam int BYTE_CNT   = DATA_WIDTH / BYTE_WIDTH,
  localparam int OFS_WIDTH  = $clog2(BYTE_CNT),
  localparam int BEAT_WIDTH = LEN_WIDTH - OFS_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_vld,
  output logic                  o_cmd_rdy,
  input  logic [ADDR_WIDTH-1:0] i_cmd_s_addr,
  input  logic [ADDR_WIDTH-1:0] i_cmd_m_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  output logic                  o_conv_vld,
  input  logic                  i_conv_rdy,
  output logic [OFS_WIDTH-1:0]  o_conv_s_ofs,
  output logic [OFS_WIDTH-1:0]  o_conv_m_ofs,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvld,
  output logic                  s_axis_trdy,
`ifdef STR_KEEP_GEN_FRAME_CHK_EN
  output logic                  o_err,
`endif
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [BYTE_CNT-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvld,
  input  logic                  m_axis_trdy
);

  // Handshakes: a transfer happens on a rising clock edge where valid and
  // ready are both high; valid never drops and payload never changes while
  // valid is high and ready is low.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [BYTE_CNT-1:0] ALL_ONES = '1;

  state_t                state_q, state_d;
  logic [OFS_WIDTH-1:0]  s_ofs_q, m_ofs_q, end_ofs_q;
  logic [BEAT_WIDTH-1:0] beats_q, beat_cnt_q;
  logic                  first_q;

  logic                  cmd_hs, conv_hs, raw_acc, is_last;
  logic [LEN_WIDTH:0]    cmd_sum, cmd_round;
  logic [OFS_WIDTH:0]    last_shift;
  logic [BYTE_CNT-1:0]   first_mask, last_mask, beat_keep;
  logic                  unused_addr;

  // Beat count is ceil((s_ofs + len) / BYTE_CNT); the sum cannot overflow LEN_WIDTH+1 bits.
  assign cmd_sum   = {1'b0, i_cmd_len} + (LEN_WIDTH+1)'(i_cmd_s_addr[OFS_WIDTH-1:0]);
  assign cmd_round = cmd_sum + (LEN_WIDTH+1)'(BYTE_CNT - 1);

  assign cmd_hs  = i_cmd_vld & o_cmd_rdy;
  assign conv_hs = o_conv_vld & i_conv_rdy;
  assign raw_acc = s_axis_tvld & s_axis_trdy;
  assign is_last = (beat_cnt_q == '0);

  assign o_conv_s_ofs = s_ofs_q;
  assign o_conv_m_ofs = m_ofs_q;

  assign last_shift = (OFS_WIDTH+1)'(BYTE_CNT) - {1'b0, end_ofs_q};
  assign first_mask = ALL_ONES << s_ofs_q;
  assign last_mask  = (end_ofs_q != '0) ? (ALL_ONES >> last_shift) : ALL_ONES;
  assign beat_keep  = (first_q ? first_mask : ALL_ONES) & (is_last ? last_mask : ALL_ONES);

  assign unused_addr = ^{i_cmd_s_addr[ADDR_WIDTH-1:OFS_WIDTH],
                         i_cmd_m_addr[ADDR_WIDTH-1:OFS_WIDTH],
                         cmd_round[OFS_WIDTH-1:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    o_cmd_rdy   = 1'b0;
    o_conv_vld  = 1'b0;
    s_axis_trdy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_cmd_rdy = 1'b1;
        // A zero-length command is swallowed without leaving IDLE.
        if (i_cmd_vld && (i_cmd_len != '0)) state_d = ST_CONV;
      end
      ST_CONV: begin
        o_conv_vld = 1'b1;
        if (i_conv_rdy) state_d = ST_DATA;
      end
      ST_DATA: begin
        s_axis_trdy = !m_axis_tvld || m_axis_trdy;
        if (s_axis_trdy && s_axis_tvld && is_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_ofs_q      <= '0;
      m_ofs_q      <= '0;
      end_ofs_q    <= '0;
      beats_q      <= '0;
      beat_cnt_q   <= '0;
      first_q      <= 1'b0;
      m_axis_tvld  <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      if (cmd_hs) begin
        s_ofs_q   <= i_cmd_s_addr[OFS_WIDTH-1:0];
        m_ofs_q   <= i_cmd_m_addr[OFS_WIDTH-1:0];
        end_ofs_q <= cmd_sum[OFS_WIDTH-1:0];
        beats_q   <= cmd_round[LEN_WIDTH:OFS_WIDTH];
      end
      if (conv_hs) begin
        beat_cnt_q <= beats_q - BEAT_WIDTH'(1);
        first_q    <= 1'b1;
      end else if (raw_acc) begin
        beat_cnt_q <= beat_cnt_q - BEAT_WIDTH'(1);
        first_q    <= 1'b0;
      end
      // Single output register; it only reloads when empty or draining.
      if (raw_acc) begin
        m_axis_tvld  <= 1'b1;
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= beat_keep;
        m_axis_tlast <= is_last;
      end else if (m_axis_trdy) begin
        m_axis_tvld <= 1'b0;
      end
    end
  end

`ifdef STR_KEEP_GEN_FRAME_CHK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_err <= 1'b0;
    else       o_err <= raw_acc && (s_axis_tlast != is_last);
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

endmodule

// File: tb/tb_str_keep_gen.sv
// Directed bench for str_keep_gen: byte-range keep model, expected queues and
// one negedge compare process for conv, output beats, hold stability and o_err.
module tb_str_keep_gen;

  localparam int DW = 512;
  localparam int BC = 64;
  localparam int OW = 6;
  localparam int AW = 32;
  localparam int LW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tlast;
    logic          last_true;
  } raw_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_cmd_vld = 1'b0;
  logic          o_cmd_rdy;
  logic [AW-1:0] i_cmd_s_addr = '0;
  logic [AW-1:0] i_cmd_m_addr = '0;
  logic [LW-1:0] i_cmd_len = '0;
  logic          o_conv_vld;
  logic          i_conv_rdy = 1'b0;
  logic [OW-1:0] o_conv_s_ofs, o_conv_m_ofs;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvld = 1'b0;
  logic          s_axis_trdy;
  logic [DW-1:0] m_axis_tdata;
  logic [BC-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvld;
  logic          m_axis_trdy = 1'b0;
  logic          o_err;

  str_keep_gen dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy),
    .i_cmd_s_addr(i_cmd_s_addr), .i_cmd_m_addr(i_cmd_m_addr), .i_cmd_len(i_cmd_len),
    .o_conv_vld(o_conv_vld), .i_conv_rdy(i_conv_rdy),
    .o_conv_s_ofs(o_conv_s_ofs), .o_conv_m_ofs(o_conv_m_ofs),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvld(s_axis_tvld), .s_axis_trdy(s_axis_trdy),
`ifdef STR_KEEP_GEN_FRAME_CHK_EN
    .o_err(o_err),
`endif
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvld(m_axis_tvld), .m_axis_trdy(m_axis_trdy)
  );

`ifndef STR_KEEP_GEN_FRAME_CHK_EN
  assign o_err = 1'b0;
`endif

  // Clock / reset
  always #5 i_clk = ~i_clk;

  // Scoreboard state
  raw_t            raw_q[$];
  logic [DW-1:0]   exp_q[$];
  logic [BC-1:0]   exp_keep_q[$];
  logic            exp_last_q[$];
  logic [2*OW-1:0] exp_conv_q[$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   out_beats = 0;
  int   err_cnt = 0;
  int   trdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int   conv_mode = 0;   // 0: always ready, 1: random
  logic raw_hs = 1'b0;
  logic err_exp = 1'b0;
  logic stall_prev = 1'b0;
  logic [DW-1:0] held_data;
  logic [BC-1:0] held_keep;
  logic          held_last;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a beat's keep bit is set when that byte position lies inside
  // the byte range [s_ofs, s_ofs+len) measured from the first aligned beat.
  function automatic logic [BC-1:0] keep_model(input int s_ofs, input int len, input int beat);
    logic [BC-1:0] k;
    for (int j = 0; j < BC; j++) begin
      int pos;
      pos = beat * BC + j;
      k[j] = (pos >= s_ofs) && (pos < s_ofs + len);
    end
    return k;
  endfunction

  function automatic int beats_model(input int s_ofs, input int len);
    return (s_ofs + len + BC - 1) / BC;
  endfunction

  // Driver tasks
  task automatic do_cmd(input logic [AW-1:0] sa, input logic [AW-1:0] ma, input int len, input bit bad_first);
    int   so, mo, nb;
    logic got;
    raw_t r;
    so = int'(sa[OW-1:0]);
    mo = int'(ma[OW-1:0]);
    if (len != 0) begin
      exp_conv_q.push_back({sa[OW-1:0], ma[OW-1:0]});
      nb = beats_model(so, len);
      for (int i = 0; i < nb; i++) begin
        for (int w = 0; w < DW / 32; w++) r.data[w*32 +: 32] = $urandom();
        r.last_true = (i == nb - 1);
        r.tlast     = r.last_true | (bad_first && i == 0);
        raw_q.push_back(r);
        exp_q.push_back(r.data);
        exp_keep_q.push_back(keep_model(so, len, i));
        exp_last_q.push_back(i == nb - 1);
      end
    end
    @(posedge i_clk); #1;
    i_cmd_s_addr = sa;
    i_cmd_m_addr = ma;
    i_cmd_len    = LW'(len);
    i_cmd_vld    = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge i_clk);
      if (o_cmd_rdy) begin
        got = 1'b1;
        break;
      end
    end
    chk("cmd_accept_timeout", got, 1'b1);
    @(posedge i_clk); #1;
    i_cmd_vld = 1'b0;
    chk("conv_vld_next_cycle", o_conv_vld, (len != 0));
    if (len == 0) chk("len0_stays_idle", o_cmd_rdy, 1'b1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge i_clk); #1;
      if (exp_q.size() == 0 && exp_conv_q.size() == 0 && !m_axis_tvld) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", done, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_rdy"}, o_cmd_rdy, 1'b1);
    chk({tag, "_conv_vld"}, o_conv_vld, 1'b0);
    chk({tag, "_m_tvld"}, m_axis_tvld, 1'b0);
    chk({tag, "_m_tlast"}, m_axis_tlast, 1'b0);
    chk({tag, "_m_tkeep"}, m_axis_tkeep, '0);
    chk({tag, "_m_tdata"}, m_axis_tdata, '0);
    chk({tag, "_s_trdy"}, s_axis_trdy, 1'b0);
    chk({tag, "_err"}, o_err, 1'b0);
  endtask

  // Raw source: offers queued beats in order, pops on observed handshake
  initial begin
    forever begin
      @(posedge i_clk); #1;
      if (raw_hs && raw_q.size() > 0) raw_q.delete(0);
      if (raw_q.size() > 0) begin
        s_axis_tvld  = 1'b1;
        s_axis_tdata = raw_q[0].data;
        s_axis_tlast = raw_q[0].tlast;
      end else begin
        s_axis_tvld  = 1'b0;
        s_axis_tlast = 1'b0;
      end
    end
  end

  // Ready drivers
  initial begin
    forever begin
      @(posedge i_clk); #1;
      m_axis_trdy = (trdy_mode == 0) ? 1'b1 : (trdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_conv_rdy  = (conv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Compare process
  always @(negedge i_clk) begin
    if (i_rst) begin
      raw_hs     = 1'b0;
      err_exp    = 1'b0;
      stall_prev = 1'b0;
    end else begin
`ifdef STR_KEEP_GEN_FRAME_CHK_EN
      chk("err_pulse", o_err, err_exp);
      if (o_err) err_cnt++;
`endif
      raw_hs  = s_axis_tvld && s_axis_trdy;
      err_exp = raw_hs && raw_q.size() > 0 && (raw_q[0].tlast != raw_q[0].last_true);
      if (o_conv_vld && i_conv_rdy) begin
        if (exp_conv_q.size() == 0) chk("conv_unexpected", 1'b1, 1'b0);
        else begin
          logic [2*OW-1:0] e;
          e = exp_conv_q.pop_front();
          chk("conv_s_ofs", o_conv_s_ofs, e[2*OW-1:OW]);
          chk("conv_m_ofs", o_conv_m_ofs, e[OW-1:0]);
        end
      end
      if (stall_prev) begin
        chk("hold_tvld", m_axis_tvld, 1'b1);
        chk("hold_tdata", m_axis_tdata, held_data);
        chk("hold_tkeep", m_axis_tkeep, held_keep);
        chk("hold_tlast", m_axis_tlast, held_last);
      end
      if (m_axis_tvld && m_axis_trdy) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1'b1, 1'b0);
        else begin
          chk("beat_tdata", m_axis_tdata, exp_q.pop_front());
          chk("beat_tkeep", m_axis_tkeep, exp_keep_q.pop_front());
          chk("beat_tlast", m_axis_tlast, exp_last_q.pop_front());
        end
        out_beats++;
      end
      stall_prev = m_axis_tvld && !m_axis_trdy;
      held_data  = m_axis_tdata;
      held_keep  = m_axis_tkeep;
      held_last  = m_axis_tlast;
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Test sequence and final report
  initial begin
    int   ob0, eb0;
    logic seen;
    #1 i_rst = 1'b1;
    #2 chk_reset_outputs("reset");
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Hand-computed pins on the model itself
    chk("model_keep0", keep_model(5, 200, 0), 64'hFFFF_FFFF_FFFF_FFE0);
    chk("model_keep1", keep_model(5, 200, 1), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("model_keep3", keep_model(5, 200, 3), 64'h1FFF);
    chk("model_beats", beats_model(5, 200), 4);
    chk("model_single", keep_model(16, 4, 0), 64'hF0000);

    // Multi-beat unaligned, single beat, aligned
    ob0 = out_beats;
    do_cmd(32'h1005, 32'h2000, 200, 1'b0);
    wait_idle();
    chk("multi_beat_count", out_beats - ob0, 4);
    do_cmd(32'h10, 32'h0, 4, 1'b0);
    wait_idle();
    do_cmd(32'h40, 32'h7, 128, 1'b0);
    wait_idle();

    // Zero length then one full beat
    ob0 = out_beats;
    do_cmd(32'h80, 32'h3, 0, 1'b0);
    do_cmd(32'hC0, 32'h9, 64, 1'b0);
    wait_idle();
    chk("len0_then_64_beats", out_beats - ob0, 1);

    // Random backpressure, back-to-back commands
    trdy_mode = 1;
    conv_mode = 1;
    do_cmd(32'h1233, 32'h45, 300, 1'b0);
    do_cmd(32'h2007, 32'h11, 150, 1'b0);
    wait_idle();

    // Next conv issued while previous last beat is still held
    trdy_mode = 2;
    conv_mode = 0;
    do_cmd(32'h0, 32'h0, 64, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      if (m_axis_tvld) begin
        seen = 1'b1;
        break;
      end
    end
    chk("overlap_first_beat", seen, 1'b1);
    do_cmd(32'h100, 32'h1, 70, 1'b0);
    chk("overlap_last_held", m_axis_tvld & m_axis_tlast, 1'b1);
    trdy_mode = 0;
    wait_idle();

    // Asynchronous reset in the middle of a 4-beat transfer
    ob0 = out_beats;
    do_cmd(32'h0, 32'h0, 256, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk); #1;
      if (out_beats == ob0 + 1 && m_axis_tvld) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reset_reach_beat2", seen, 1'b1);
    #1 i_rst = 1'b1;
    raw_q.delete();
    exp_q.delete();
    exp_keep_q.delete();
    exp_last_q.delete();
    exp_conv_q.delete();
    raw_hs = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(posedge i_clk);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    eb0 = out_beats;
    do_cmd(32'h3, 32'h5, 70, 1'b0);
    wait_idle();
    chk("post_reset_beats", out_beats - eb0, 2);

`ifdef STR_KEEP_GEN_FRAME_CHK_EN
    eb0 = err_cnt;
    do_cmd(32'h0, 32'h0, 256, 1'b1);
    wait_idle();
    chk("early_tlast_err_count", err_cnt - eb0, 1);
`endif

    chk("raw_q_empty", raw_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
